// File: rtl/nios2core_gpio_edgecap_pkg.sv
// Shared constants for the GPIO edge-capture block: register addresses,
// CTRL bit positions and the debounce counter width.
package nios2core_gpio_edgecap_pkg;

  localparam logic [1:0] ADDR_LEVEL   = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int CTRL_RISE = 0;
  localparam int CTRL_FALL = 1;

  localparam int DEB_W = 4;

  function automatic logic bus_write(input logic cs, input logic wr_n);
    return cs & ~wr_n;
  endfunction

endpackage

// File: rtl/nios2core_gpio_edgecap_if.sv
// Avalon-MM slave bus bundle for the GPIO edge-capture block, plus its irq line.
interface nios2core_gpio_edgecap_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/nios2core_gpio_debounce_bit.sv
// One-pin debounce filter: accepts a new level only after DEB_COUNT
// consecutive prescaler ticks on which the synchronised input disagreed.
module nios2core_gpio_debounce_bit
  import nios2core_gpio_edgecap_pkg::*;
#(
  parameter int DEB_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic lvl
);

  logic [DEB_W-1:0] r_cnt;
  logic             r_lvl;

  // Any agreeing cycle restarts the count, so glitches never accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {DEB_W{1'b0}};
      r_lvl <= 1'b0;
    end else if (din == r_lvl) begin
      r_cnt <= {DEB_W{1'b0}};
    end else if (tick) begin
      if (r_cnt == DEB_W'(DEB_COUNT - 1)) begin
        r_lvl <= ~r_lvl;
        r_cnt <= {DEB_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign lvl = r_lvl;

endmodule

// File: rtl/nios2core_gpio_edgecap.sv
// GPIO input conditioning and edge capture with a level interrupt.
// Define NIOS2CORE_GPIO_EDGECAP_DEBOUNCE_EN to add the prescaled debounce filter.
module nios2core_gpio_edgecap
  import nios2core_gpio_edgecap_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int DIV       = 50000,
  parameter int DEB_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       pins_in,
  nios2core_gpio_edgecap_if.slave bus
);

  logic [WIDTH-1:0] r_sync1, r_sync2, r_lvl_d, r_edgecap, r_irqmask;
  logic [WIDTH-1:0] w_lvl, w_set, w_clr;
  logic [1:0]       r_ctrl;
  logic [31:0]      r_readdata, w_rdata;
  logic             w_wr;

  assign w_wr = bus_write(bus.chipselect, bus.write_n);

`ifdef NIOS2CORE_GPIO_EDGECAP_DEBOUNCE_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(DIV - 1));

  // Free-running prescaler shared by all pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= {PW{1'b0}};
    end else if (w_tick) begin
      r_presc <= {PW{1'b0}};
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    nios2core_gpio_debounce_bit #(.DEB_COUNT(DEB_COUNT)) u_deb (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick),
      .din   (r_sync2[i]),
      .lvl   (w_lvl[i])
    );
  end
`else
  localparam int unused_cfg = DIV + DEB_COUNT;
  assign w_lvl = r_sync2;
`endif

  assign w_set = (w_lvl & ~r_lvl_d & {WIDTH{r_ctrl[CTRL_RISE]}}) |
                 (~w_lvl & r_lvl_d & {WIDTH{r_ctrl[CTRL_FALL]}});

  // W1C mask for EDGECAP; upper writedata bits beyond WIDTH are dropped.
  always_comb begin
    w_clr = {WIDTH{1'b0}};
    if (w_wr && (bus.address == ADDR_EDGECAP)) begin
      w_clr = bus.writedata[WIDTH-1:0];
    end else begin
      w_clr = {WIDTH{1'b0}};
    end
  end

  // Read mux, zero-extended; sampled every cycle regardless of chipselect.
  always_comb begin
    w_rdata = 32'd0;
    case (bus.address)
      ADDR_LEVEL:   w_rdata = 32'(w_lvl);
      ADDR_IRQMASK: w_rdata = 32'(r_irqmask);
      ADDR_EDGECAP: w_rdata = 32'(r_edgecap);
      ADDR_CTRL:    w_rdata = {30'd0, r_ctrl};
      default:      w_rdata = 32'd0;
    endcase
  end

  // Synchroniser, edge history, register file and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= {WIDTH{1'b0}};
      r_sync2    <= {WIDTH{1'b0}};
      r_lvl_d    <= {WIDTH{1'b0}};
      r_edgecap  <= {WIDTH{1'b0}};
      r_irqmask  <= {WIDTH{1'b0}};
      r_ctrl     <= 2'b00;
      r_readdata <= 32'd0;
    end else begin
      r_sync1    <= pins_in;
      r_sync2    <= r_sync1;
      r_lvl_d    <= w_lvl;
      r_edgecap  <= (r_edgecap & ~w_clr) | w_set;
      r_readdata <= w_rdata;
      if (w_wr && (bus.address == ADDR_IRQMASK)) begin
        r_irqmask <= bus.writedata[WIDTH-1:0];
      end
      if (w_wr && (bus.address == ADDR_CTRL)) begin
        r_ctrl <= bus.writedata[1:0];
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios2core_gpio_edgecap.sv
// Directed self-checking bench for nios2core_gpio_edgecap; the debounce part
// runs when NIOS2CORE_GPIO_EDGECAP_DEBOUNCE_EN is defined (DIV=4, DEB_COUNT=3).
module tb_nios2core_gpio_edgecap;
  import nios2core_gpio_edgecap_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] pins_in;
  int          checks = 0;
  int          errors = 0;

  nios2core_gpio_edgecap_if bus_if ();

  nios2core_gpio_edgecap #(.WIDTH(28), .DIV(4), .DEB_COUNT(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .pins_in (pins_in),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    @(posedge clk);
    #1;
    d = bus_if.readdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        found;
    int          n;

    reset = 1'b1;
    pins_in = 28'd0;
    bus_if.address = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n = 1'b1;
    bus_if.writedata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    rd(ADDR_LEVEL, d);   chk("rst_level", d, 32'd0);
    rd(ADDR_IRQMASK, d); chk("rst_irqmask", d, 32'd0);
    rd(ADDR_EDGECAP, d); chk("rst_edgecap", d, 32'd0);
    rd(ADDR_CTRL, d);    chk("rst_ctrl", d, 32'd0);
    chk("rst_irq", {31'd0, bus_if.irq}, 32'd0);

`ifndef NIOS2CORE_GPIO_EDGECAP_DEBOUNCE_EN
    wr(ADDR_CTRL, 32'h1);
    wr(ADDR_IRQMASK, 32'h1);
    rd(ADDR_CTRL, d);    chk("ctrl_rb", d, 32'h1);
    rd(ADDR_IRQMASK, d); chk("mask_rb", d, 32'h1);

    // Rise on bit 0: irq expected exactly after the third edge.
    @(negedge clk); pins_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rise0_irq_early", {31'd0, bus_if.irq}, 32'd0);
    @(posedge clk); #1;
    chk("rise0_irq", {31'd0, bus_if.irq}, 32'd1);
    rd(ADDR_EDGECAP, d); chk("rise0_edgecap", d, 32'h1);

    wr(ADDR_EDGECAP, 32'h1);
    chk("w1c_irq", {31'd0, bus_if.irq}, 32'd0);
    rd(ADDR_EDGECAP, d); chk("w1c_edgecap", d, 32'h0);

    // Fall-only capture on bit 5 with irq masked off.
    wr(ADDR_CTRL, 32'h2);
    wr(ADDR_IRQMASK, 32'h0);
    @(negedge clk); pins_in[5] = 1'b1;
    repeat (4) @(posedge clk);
    rd(ADDR_EDGECAP, d); chk("rise5_ignored", d, 32'h0);
    @(negedge clk); pins_in[5] = 1'b0;
    repeat (4) @(posedge clk);
    rd(ADDR_EDGECAP, d); chk("fall5_edgecap", d, 32'h20);
    chk("fall5_irq_masked", {31'd0, bus_if.irq}, 32'd0);

    // Set and W1C on the same edge: set wins.
    wr(ADDR_EDGECAP, 32'h20);
    wr(ADDR_CTRL, 32'h1);
    @(negedge clk); pins_in[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(ADDR_EDGECAP, 32'h8);
    rd(ADDR_EDGECAP, d); chk("set_wins", d, 32'h8);

    wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
    chk("mask_all_irq", {31'd0, bus_if.irq}, 32'd1);
    rd(ADDR_IRQMASK, d); chk("mask_upper_dropped", d, 32'h0FFF_FFFF);
    wr(ADDR_LEVEL, 32'h0000_FFFF);
    rd(ADDR_LEVEL, d);   chk("level_ro", d, 32'h9);

    // Asynchronous reset in the middle of operation.
    @(negedge clk); reset = 1'b1;
    #1;
    chk("arst_readdata", bus_if.readdata, 32'd0);
    chk("arst_irq", {31'd0, bus_if.irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(ADDR_IRQMASK, d); chk("arst_irqmask", d, 32'd0);
    rd(ADDR_EDGECAP, d); chk("arst_edgecap", d, 32'd0);
    rd(ADDR_CTRL, d);    chk("arst_ctrl", d, 32'd0);
`else
    wr(ADDR_CTRL, 32'h3);
    wr(ADDR_IRQMASK, 32'h2);

    // 6-cycle pulse spans at most two ticks, fewer than DEB_COUNT.
    @(negedge clk); pins_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    pins_in[1] = 1'b0;
    repeat (20) @(posedge clk);
    rd(ADDR_LEVEL, d);   chk("pulse_level", d, 32'd0);
    rd(ADDR_EDGECAP, d); chk("pulse_edgecap", d, 32'd0);

    @(negedge clk); pins_in[1] = 1'b1;
    found = 1'b0; n = 0;
    for (int j = 1; j <= 30 && !found; j++) begin
      rd(ADDR_LEVEL, d);
      if (d[1]) begin found = 1'b1; n = j; end
    end
    chk("deb_rise_found", {31'd0, found}, 32'd1);
    chk("deb_rise_latency", {31'd0, (n <= 15)}, 32'd1);
    rd(ADDR_EDGECAP, d); chk("deb_rise_edgecap", d, 32'h2);
    chk("deb_rise_irq", {31'd0, bus_if.irq}, 32'd1);

    @(negedge clk); pins_in[1] = 1'b0;
    found = 1'b0;
    for (int j = 1; j <= 30 && !found; j++) begin
      rd(ADDR_LEVEL, d);
      if (!d[1]) found = 1'b1;
    end
    chk("deb_fall_found", {31'd0, found}, 32'd1);
    wr(ADDR_EDGECAP, 32'h2);

    // Two ticks into a debounce on bit 2, then reset.
    @(negedge clk); pins_in[2] = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("arst_readdata", bus_if.readdata, 32'd0);
    chk("arst_irq", {31'd0, bus_if.irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(ADDR_LEVEL, d);   chk("arst_level", d, 32'd0);
    rd(ADDR_IRQMASK, d); chk("arst_irqmask", d, 32'd0);
    rd(ADDR_EDGECAP, d); chk("arst_edgecap", d, 32'd0);
    rd(ADDR_CTRL, d);    chk("arst_ctrl", d, 32'd0);
    for (int j = 0; j < 6; j++) rd(ADDR_LEVEL, d);
    chk("arst_count_restarted", d, 32'd0);
    found = 1'b0;
    for (int j = 1; j <= 30 && !found; j++) begin
      rd(ADDR_LEVEL, d);
      if (d[2]) found = 1'b1;
    end
    chk("arst_rise_found", {31'd0, found}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
